// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin arbiter merging NUM_PORTS AXI-Stream
// inputs onto one AXI-Stream output. A grant is held from the first beat until the
// tlast handshake, so packets never interleave.
// Optional feature macro: AXIS_RR_ARBITER_TID_TAG_EN replaces the low IDX_BITS of
// m_tid with the granted source index (requires TID_BITS >= IDX_BITS).
module axis_rr_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned TDATA_BYTES = 4,
  parameter int unsigned TID_BITS    = 1,
  parameter int unsigned TDEST_BITS  = 1,
  parameter int unsigned TUSER_BITS  = 1,
  localparam int unsigned IDX_BITS   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [NUM_PORTS-1:0]              s_tvalid,
  output logic [NUM_PORTS-1:0]              s_tready,
  input  logic [NUM_PORTS*TDATA_BYTES*8-1:0] s_tdata,
  input  logic [NUM_PORTS*TDATA_BYTES-1:0]  s_tstrb,
  input  logic [NUM_PORTS*TDATA_BYTES-1:0]  s_tkeep,
  input  logic [NUM_PORTS-1:0]              s_tlast,
  input  logic [NUM_PORTS*TID_BITS-1:0]     s_tid,
  input  logic [NUM_PORTS*TDEST_BITS-1:0]   s_tdest,
  input  logic [NUM_PORTS*TUSER_BITS-1:0]   s_tuser,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [TDATA_BYTES*8-1:0]          m_tdata,
  output logic [TDATA_BYTES-1:0]            m_tstrb,
  output logic [TDATA_BYTES-1:0]            m_tkeep,
  output logic                              m_tlast,
  output logic [TID_BITS-1:0]               m_tid,
  output logic [TDEST_BITS-1:0]             m_tdest,
  output logic [TUSER_BITS-1:0]             m_tuser,
  output logic                              grant_valid,
  output logic [IDX_BITS-1:0]               grant_idx
);

  localparam int unsigned DW = TDATA_BYTES * 8;
  localparam int unsigned CW = IDX_BITS + 1;

`ifdef AXIS_RR_ARBITER_TID_TAG_EN
  if (TID_BITS < IDX_BITS) begin : g_tid_too_narrow
    $error("axis_rr_arbiter: TID_BITS must be >= IDX_BITS when source tagging is enabled");
  end
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_BITS-1:0] r_grant_idx;
  logic [IDX_BITS-1:0] w_grant_idx_nxt;
  logic [IDX_BITS-1:0] r_rr_ptr;
  logic [IDX_BITS-1:0] w_rr_ptr_nxt;
  logic                r_grant_valid;
  logic                w_grant_valid_nxt;
  logic [IDX_BITS-1:0] w_win_idx;
  logic                w_win_found;
  logic [CW-1:0]       w_cand;
  logic                w_pass;
  logic                w_accept;

  // Data path is live only while a packet is granted and not being reset.
  assign w_pass      = (r_state == ST_PASS) && !areset;
  assign w_accept    = m_tvalid && m_tready;
  assign grant_valid = r_grant_valid;
  assign grant_idx   = r_grant_idx;

  // Round-robin search: first requester at or after rr_ptr, wrapping at NUM_PORTS-1.
  always_comb begin
    w_win_idx   = '0;
    w_win_found = 1'b0;
    w_cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      w_cand = {1'b0, r_rr_ptr} + CW'(i);
      if (w_cand >= CW'(NUM_PORTS)) begin
        w_cand = w_cand - CW'(NUM_PORTS);
      end
      if (!w_win_found && s_tvalid[w_cand[IDX_BITS-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand[IDX_BITS-1:0];
      end
    end
  end

  // Next state: lock the grant for a packet, release and advance pointer on tlast handshake.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_idx_nxt   = r_grant_idx;
    w_grant_valid_nxt = r_grant_valid;
    w_rr_ptr_nxt      = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_win_found) begin
          w_state_nxt       = ST_PASS;
          w_grant_idx_nxt   = w_win_idx;
          w_grant_valid_nxt = 1'b1;
        end
      end
      ST_PASS: begin
        if (w_accept && m_tlast) begin
          w_state_nxt       = ST_IDLE;
          w_grant_valid_nxt = 1'b0;
          w_rr_ptr_nxt      = (r_grant_idx == IDX_BITS'(NUM_PORTS - 1)) ?
                              '0 : r_grant_idx + IDX_BITS'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Combinational pass-through of the granted slice; all zero outside a grant.
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tstrb  = '0;
    m_tkeep  = '0;
    m_tlast  = 1'b0;
    m_tid    = '0;
    m_tdest  = '0;
    m_tuser  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (w_pass && (r_grant_idx == IDX_BITS'(p))) begin
        s_tready[p] = m_tready;
        m_tvalid    = s_tvalid[p];
        m_tdata     = s_tdata[p*DW +: DW];
        m_tstrb     = s_tstrb[p*TDATA_BYTES +: TDATA_BYTES];
        m_tkeep     = s_tkeep[p*TDATA_BYTES +: TDATA_BYTES];
        m_tlast     = s_tlast[p];
        m_tid       = s_tid[p*TID_BITS +: TID_BITS];
        m_tdest     = s_tdest[p*TDEST_BITS +: TDEST_BITS];
        m_tuser     = s_tuser[p*TUSER_BITS +: TUSER_BITS];
      end
    end
`ifdef AXIS_RR_ARBITER_TID_TAG_EN
    if (w_pass) begin
      m_tid[IDX_BITS-1:0] = r_grant_idx;
    end
`endif
  end

  // State and grant registers with synchronous active-high reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= ST_IDLE;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_rr_ptr      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
    end
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter: NUM_PORTS AXI-Stream slave inputs share one AXI-Stream master output.
- Grant is locked from the first beat of a packet until the tlast handshake, so packets never interleave.
- Signal set and widths match the team's axis_if; ports are flattened packed vectors (port i occupies slice i) so the block binds to axis_if arrays through a thin wrapper.
- Sits in front of any single-consumer stream resource: DMA, shared FIFO, framer.

Parameters:
- NUM_PORTS, 4, number of slave inputs (2..16).
- TDATA_BYTES, 4, bytes per tdata beat.
- TID_BITS, 1, width of tid.
- TDEST_BITS, 1, width of tdest.
- TUSER_BITS, 1, width of tuser.
- IDX_BITS (localparam), max(1, $clog2(NUM_PORTS)), grant index width.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset, synchronous, active-high.
- s_tvalid  in  NUM_PORTS  per-input tvalid.
- s_tready  out  NUM_PORTS  per-input tready.
- s_tdata  in  NUM_PORTS*TDATA_BYTES*8  per-input tdata.
- s_tstrb  in  NUM_PORTS*TDATA_BYTES  per-input tstrb.
- s_tkeep  in  NUM_PORTS*TDATA_BYTES  per-input tkeep.
- s_tlast  in  NUM_PORTS  per-input tlast.
- s_tid  in  NUM_PORTS*TID_BITS  per-input tid.
- s_tdest  in  NUM_PORTS*TDEST_BITS  per-input tdest.
- s_tuser  in  NUM_PORTS*TUSER_BITS  per-input tuser.
- m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  single-port widths  master output.
- m_tready  in  1  master tready.
- grant_valid  out  1  high while a packet is granted.
- grant_idx  out  IDX_BITS  index of the granted input.

Behaviour:
- States: IDLE, PASS.
- Reset (areset=1 at a clock edge):
  - state=IDLE, grant_valid=0, grant_idx=0, rr_ptr=0.
  - All s_tready=0, m_tvalid=0, all m_* data outputs 0.
  - Effective the same cycle it is sampled; any packet in flight is abandoned with no tlast emitted.
- IDLE:
  - All s_tready=0; m_tvalid=0; m_* data outputs driven 0.
  - If any s_tvalid is set, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_PORTS-1, 0, ...).
  - Register the winner into grant_idx, set grant_valid=1, go to PASS.
  - Arbitration latency: 1 cycle from s_tvalid seen in IDLE to m_tvalid.
- PASS:
  - Combinational pass-through of slice grant_idx: m_* = s_*[grant_idx], m_tvalid = s_tvalid[grant_idx].
  - s_tready[grant_idx] = m_tready; all other s_tready = 0.
  - No added latency on the data path.
  - Beat accepted when m_tvalid & m_tready.
  - Accepted beat with m_tlast=1: go to IDLE, grant_valid=0, rr_ptr = grant_idx+1, wrapping NUM_PORTS-1 → 0.
  - Granted input dropping tvalid mid-packet: grant held and m_tvalid follows it; no re-arbitration until tlast.
- Fairness:
  - One mandatory IDLE bubble cycle between packets.
  - A continuously requesting input waits at most NUM_PORTS-1 packets.
- Boundary cases:
  - Single-beat packet (tlast on the first beat): one PASS cycle if m_tready=1.
  - All inputs requesting: grants rotate 0,1,2,...,N-1,0.
  - Only the just-served input requesting: it is re-granted after the bubble.
  - Non-power-of-2 NUM_PORTS: pointer wraps at NUM_PORTS-1; unused index values never granted.
  - m_tready=0: all s_tready=0 and the input holds its beat (AXIS stall rules).
- Protocol: a granted input's m_tvalid never deasserts without a handshake, since m_tvalid is a direct copy of that input's tvalid.

Optional Feature:
- Macro AXIS_RR_ARBITER_TID_TAG_EN.
- Defined:
  - Elaboration error if TID_BITS < IDX_BITS.
  - m_tid = {s_tid[grant_idx][TID_BITS-1:IDX_BITS], grant_idx}: the low IDX_BITS bits carry the source index and the upper bits pass through.
- Undefined: m_tid = s_tid[grant_idx] unchanged.

Test Plan:
- Reset then idle: areset=1 for 3 cycles, all s_tvalid=1 → s_tready=0, m_tvalid=0, grant_valid=0 during reset; first grant afterwards goes to port 0.
- Single requester: port 2 sends 4-beat packet 0xA0..0xA3, m_tready=1 → m_tvalid one cycle after s_tvalid, beats in order, m_tlast on 0xA3, grant_idx=2, one idle cycle after.
- Round-robin: NUM_PORTS=4, all ports hold 2-beat packets continuously → grant order 0,1,2,3,0; each packet contiguous with no interleave.
- Backpressure: m_tready toggling 1,0,0,1 mid-packet → s_tready[grant] mirrors m_tready; m_tdata stable while stalled; other s_tready stay 0.
- Mid-packet gap plus reset: port 1 deasserts tvalid for 3 cycles mid-packet while port 3 requests → grant stays 1; then areset pulse → IDLE, rr_ptr=0, port 3 granted next.
- With AXIS_RR_ARBITER_TID_TAG_EN, TID_BITS=4: port 3 sends tid=4'hC → m_tid=4'hF; without the macro → m_tid=4'hC.
